// File: rtl/button_debounce_in.sv
// button_debounce_in: synchronises and debounces a raw button into level, press/release strobes and toggle
module button_debounce_in #(
   parameter int DEBOUNCE_TICKS = 16,
   parameter bit INVERT = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic toggle_o
);
   localparam int CW = DEBOUNCE_TICKS > 1 ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);
   typedef enum logic [1:0] {LOW, ARM_H, HIGH, ARM_L} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic s1_q, s2_q, level_q, level_d, rise_q, rise_d, fall_q, fall_d, toggle_q, toggle_d;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      case (state_q)
         LOW: begin
            if (s2_q) begin
               state_d = ARM_H;
               cnt_d = '0;
            end
         end
         ARM_H: begin
            if (!s2_q) begin
               state_d = LOW;
               cnt_d = '0;
            end else if (en_i) begin
               if (cnt_q == CNT_MAX) state_d = HIGH;
               else cnt_d = cnt_q + CW'(1);
            end
         end
         HIGH: begin
            if (!s2_q) begin
               state_d = ARM_L;
               cnt_d = '0;
            end
         end
         ARM_L: begin
            if (s2_q) begin
               state_d = HIGH;
               cnt_d = '0;
            end else if (en_i) begin
               if (cnt_q == CNT_MAX) state_d = LOW;
               else cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = LOW;
      endcase
      level_d = (state_d == HIGH) || (state_d == ARM_L);
      rise_d = (state_q == ARM_H) && (state_d == HIGH);
      fall_d = (state_q == ARM_L) && (state_d == LOW);
      toggle_d = toggle_q ^ rise_d;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         state_q <= LOW;
         cnt_q <= '0;
         level_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         s1_q <= btn_i ^ INVERT;
         s2_q <= s1_q;
         state_q <= state_d;
         cnt_q <= cnt_d;
         level_q <= level_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         toggle_q <= toggle_d;
      end
   end
   assign level_o = level_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign toggle_o = toggle_q;
endmodule

// File: tb/tb_button_debounce_in.sv
// tb_button_debounce_in: vector table, directed corner cases and random stimulus against a tick-counting model
module tb_button_debounce_in;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic [1:0] rst, en, btn, lvl, ris, fal, tog;
   int errors = 0, checks = 0;
   button_debounce_in #(.DEBOUNCE_TICKS(4), .INVERT(1'b0)) u4 (
      .clk_i(clk), .rst_i(rst[0]), .en_i(en[0]), .btn_i(btn[0]),
      .level_o(lvl[0]), .rise_o(ris[0]), .fall_o(fal[0]), .toggle_o(tog[0]));
   button_debounce_in #(.DEBOUNCE_TICKS(3), .INVERT(1'b1)) u3 (
      .clk_i(clk), .rst_i(rst[1]), .en_i(en[1]), .btn_i(btn[1]),
      .level_o(lvl[1]), .rise_o(ris[1]), .fall_o(fal[1]), .toggle_o(tog[1]));
   int dt[2] = '{4, 3};
   int inv[2] = '{0, 1};
   int m_s0[2], m_s1[2], m_l[2], m_run[2], m_tk[2], m_r[2], m_f[2], m_t[2];
   typedef struct {
      logic rst, en, btn, lvl, rise, fall, tog;
   } vec_t;
   vec_t tbl[18];
   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
      end
   endtask
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            m_s0[i] = 0; m_s1[i] = 0; m_l[i] = 0; m_run[i] = 0;
            m_tk[i] = 0; m_r[i] = 0; m_f[i] = 0; m_t[i] = 0;
         end else begin
            int s2, r, f;
            s2 = m_s1[i]; r = 0; f = 0;
            if (s2 != m_l[i]) begin
               m_run[i]++;
               if (m_run[i] > 1 && en[i]) m_tk[i]++;
               if (m_tk[i] == dt[i]) begin
                  m_l[i] = s2; r = s2; f = 1 - s2; m_t[i] ^= s2;
                  m_run[i] = 0; m_tk[i] = 0;
               end
            end else begin
               m_run[i] = 0; m_tk[i] = 0;
            end
            m_r[i] = r; m_f[i] = f;
            m_s1[i] = m_s0[i];
            m_s0[i] = int'(btn[i]) ^ inv[i];
         end
      end
   endtask
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("model_level%0d", i), lvl[i], m_l[i][0]);
         chk($sformatf("model_rise%0d", i), ris[i], m_r[i][0]);
         chk($sformatf("model_fall%0d", i), fal[i], m_f[i][0]);
         chk($sformatf("model_toggle%0d", i), tog[i], m_t[i][0]);
         chk($sformatf("no_overlap%0d", i), ris[i] & fal[i], 1'b0);
      end
   endtask
   task automatic reset_one(input int i);
      rst[i] = 1'b1;
      tick();
      tick();
      rst[i] = 1'b0;
   endtask
   initial begin
      int k, nr, nf, hold[2];
      logic en_used;
      rst = 2'b11; en = 2'b11; btn = 2'b11;
      tbl[0]  = '{1, 1, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 1, 0, 0, 0, 0};
      for (int j = 2; j < 8; j++) tbl[j] = '{0, 1, 1, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 1, 1, 1, 0, 1};
      tbl[9]  = '{0, 1, 1, 1, 0, 0, 1};
      for (int j = 10; j < 16; j++) tbl[j] = '{0, 1, 0, 1, 0, 0, 1};
      tbl[16] = '{0, 1, 0, 0, 0, 1, 1};
      tbl[17] = '{0, 1, 0, 0, 0, 0, 1};
      @(negedge clk);
      // reset, clean press and clean release on the 4-tick instance
      for (int j = 0; j < 18; j++) begin
         rst[0] = tbl[j].rst; en[0] = tbl[j].en; btn[0] = tbl[j].btn;
         if (j == 2) rst[1] = 1'b0;
         tick();
         chk($sformatf("tbl%0d_level", j), lvl[0], tbl[j].lvl);
         chk($sformatf("tbl%0d_rise", j), ris[0], tbl[j].rise);
         chk($sformatf("tbl%0d_fall", j), fal[0], tbl[j].fall);
         chk($sformatf("tbl%0d_toggle", j), tog[0], tbl[j].tog);
      end
      // bounce: 1,1,0,1,1,0 must not be accepted; steady 1 accepted 7 edges later
      foreach (tbl[j]) if (j < 6) begin
         btn[0] = (j == 2 || j == 5) ? 1'b0 : 1'b1;
         tick();
         chk("bounce_no_rise", ris[0], 1'b0);
      end
      btn[0] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         chk($sformatf("bounce_rise_e%0d", e), ris[0], e == 7);
      end
      // two press/release cycles from reset
      btn[0] = 1'b0;
      reset_one(0);
      nr = 0; nf = 0;
      for (int p = 0; p < 2; p++) begin
         btn[0] = 1'b1;
         for (int e = 0; e < 12; e++) begin tick(); nr += ris[0]; end
         chk($sformatf("toggle_after_press%0d", p), tog[0], p == 0);
         btn[0] = 1'b0;
         for (int e = 0; e < 12; e++) begin tick(); nf += fal[0]; end
         chk($sformatf("toggle_after_release%0d", p), tog[0], p == 0);
      end
      chk("two_rises", nr == 2, 1'b1);
      chk("two_falls", nf == 2, 1'b1);
      // sparse tick on the 3-tick inverted instance
      btn[1] = 1'b1;
      reset_one(1);
      btn[1] = 1'b0;
      k = 0;
      for (int e = 1; e <= 30; e++) begin
         en[1] = (e % 4 == 0);
         en_used = en[1];
         tick();
         if (e >= 4 && en_used) k++;
         chk($sformatf("sparse_rise_e%0d", e), ris[1], e >= 4 && en_used && k == 3);
      end
      chk("sparse_level", lvl[1], 1'b1);
      // reset while armed with cnt=2, then full latency again
      en[1] = 1'b1;
      btn[1] = 1'b1;
      reset_one(1);
      btn[1] = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk("midcount_no_rise", ris[1], 1'b0);
      end
      rst[1] = 1'b1;
      tick();
      chk("midcount_rst_rise", ris[1], 1'b0);
      chk("midcount_rst_level", lvl[1], 1'b0);
      rst[1] = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk($sformatf("restart_rise_e%0d", e), ris[1], e == 6);
      end
      // random stimulus against the model
      hold = '{0, 0};
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (hold[i] == 0) begin
               btn[i] = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 14);
            end
            hold[i]--;
            en[i] = ($urandom_range(0, 2) != 0);
            rst[i] = ($urandom_range(0, 499) == 0);
         end
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/button_debounce_in.md
# button_debounce_in

Input-side companion to the LED-indicating enable flip-flop cell: it conditions a raw push-button or switch line from a board connector into clean, clock-synchronous level, edge-pulse and toggle signals. The block synchronises the asynchronous contact input and filters contact bounce with a tick-driven stable-time counter. It produces single-cycle press/release strobes that can drive `en_i` of downstream enable registers directly. It is built from the same 74-series merge-cell primitives (flip-flops, muxes, small counters) and sits at the board-input boundary of the design.

## Interface
- `DEBOUNCE_TICKS`, default 16: number of consecutive `en_i` ticks the synchronised input must stay stable before a change is accepted; legal range 1..255.
- `INVERT`, default 0: 1 inverts `btn_i` before the synchroniser, for active-low buttons with pull-ups.
- `clk_i`, input, 1: single clock; all state changes on its rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `en_i`, input, 1: debounce sample tick, e.g. from a prescaler; held at 1 means every cycle counts.
- `btn_i`, input, 1: raw, asynchronous contact input.
- `level_o`, output, 1: debounced level (1 = pressed).
- `rise_o`, output, 1: one-cycle strobe on an accepted press.
- `fall_o`, output, 1: one-cycle strobe on an accepted release.
- `toggle_o`, output, 1: flips on every accepted press; intended to drive an LED cell.

## Operation
- Input path: `x = btn_i XOR INVERT` feeds a two-flop synchroniser, `s1` then `s2`.
  - Both synchroniser flops clock every cycle, independent of `en_i`.
  - Only `s2` is used downstream.
- Counter: `cnt` is wide enough for `DEBOUNCE_TICKS-1`.
- FSM states and transitions:
  - LOW: `level_o=0`. If `s2=1`, go to ARM_H and set `cnt=0`.
  - ARM_H: `level_o=0`.
    - If `s2=0`, return to LOW and set `cnt=0`. This is the bounce abort, and it takes priority over `en_i`.
    - Else if `en_i=1` and `cnt==DEBOUNCE_TICKS-1`, go to HIGH.
    - Else if `en_i=1`, increment `cnt`.
    - Else hold `cnt`.
  - HIGH: `level_o=1`. If `s2=0`, go to ARM_L and set `cnt=0`.
  - ARM_L: mirror of ARM_H with the roles of 0 and 1 swapped. It completes to LOW and aborts back to HIGH.
- Strobe and toggle outputs:
  - `rise_o` is registered. It is 1 for exactly the cycle after the ARM_H→HIGH edge.
  - `fall_o` is registered. It is 1 for exactly the cycle after the ARM_L→LOW edge.
  - `toggle_o` inverts on the same edge that sets `rise_o`.
  - `rise_o` and `fall_o` are never both 1.
- All outputs are registered. There are no combinational paths from input to output.

## Timing
- Reset: on a rising edge with `rst_i=1`, the following all take 0: `s1`, `s2`, `cnt`, `level_o`, `rise_o`, `fall_o`, `toggle_o`. The FSM goes to LOW.
  - This applies mid-count, mid-strobe, and regardless of `en_i`.
  - The first edge with `rst_i=0` behaves as normal operation from the LOW state.
- Latency, with `en_i` held at 1 and `x` changing before edge 1 and then staying stable:
  - `s2` updates at edge 2.
  - The FSM enters the ARM state at edge 3.
  - `level_o` and the strobe change at edge 3+`DEBOUNCE_TICKS`.
- With a sparse `en_i`, acceptance requires `DEBOUNCE_TICKS` `en_i`-high cycles after entering the ARM state.
  - Cycles with `en_i=0` neither count nor reset the counter.
  - Any `s2` flip in the ARM state aborts the count, whether or not `en_i` is high.
- `DEBOUNCE_TICKS=1`: acceptance occurs on the first `en_i`-high edge in the ARM state.
- Glitches shorter than one clock may be missed by the synchroniser; this is acceptable.
- An accepted press followed immediately by a release needs at least 1+`DEBOUNCE_TICKS` cycles between `rise_o` and `fall_o`.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_i` for 2 cycles with `btn_i=1` and `INVERT=0`.
  - Required response: all outputs are 0 during reset and at the first post-reset edge. `level_o` rises at the 7th edge after reset release (`DEBOUNCE_TICKS=4`).
- Clean press:
  - Stimulus: `DEBOUNCE_TICKS=4`, `en_i=1`, `btn_i` 0→1 before edge 1.
  - Required response: `level_o=1`, `rise_o=1` and `toggle_o=1` after edge 7. `rise_o` returns to 0 after edge 8.
- Bounce reject:
  - Stimulus: `DEBOUNCE_TICKS=4`, `btn_i` pattern 1,1,0,1,1,0 per cycle, then steady 1.
  - Required response: no `rise_o` during the bounce. Exactly one `rise_o` occurs 7 cycles after the final 0→1 transition.
- Sparse tick:
  - Stimulus: `DEBOUNCE_TICKS=3`, `en_i` high every 4th cycle, stable press.
  - Required response: acceptance occurs only on the 3rd `en_i`-high edge after entering ARM_H. The counter holds its value between ticks.
- Toggle and release:
  - Stimulus: two full press/release cycles.
  - Required response: `toggle_o` goes 0→1→0. There are two `fall_o` pulses, each one cycle wide, and `rise_o` and `fall_o` never overlap.
- Reset mid-count with inversion:
  - Stimulus: `INVERT=1`, `btn_i` 1→0 (a press); assert `rst_i` while the FSM is in ARM_H with `cnt=2`.
  - Required response: `cnt` and the FSM return to 0/LOW and no `rise_o` is emitted. The full latency restarts after reset is released.
